// File: rtl/scaler_v_ctrl.sv
// -----------------------------------------------------------------------------
// scaler_v_ctrl
//
// Configuration controller for a vertical video scaler. A configuration write
// latches the source height, destination height and line size, computes the
// 4.12 fixed-point vertical step with a serial restoring divider, validates
// the result and then holds it until the next frame boundary (de_i & vs_i),
// where the new step and last-pixel index are applied together so the scaler
// never sees a change in the middle of a frame.
//
// Ports
//   clk                in   single clock
//   rst                in   synchronous, active-high reset
//   cfg_wr             in   one-cycle configuration write strobe
//   cfg_in_h[15:0]     in   source frame height in lines
//   cfg_out_h[15:0]    in   destination frame height in lines
//   cfg_line_size[15:0] in  pixels per line
//   de_i, vs_i         in   video strobes; both high marks the frame boundary
//   v_scale_step[15:0] out  active 4.12 vertical step
//   v_scale_line_size[15:0] out active last-pixel index
//   cfg_busy           out  computation running or apply pending
//   cfg_err            out  last write rejected (held until the next write)
//   frame_upd          out  one-cycle pulse when new values take effect
// -----------------------------------------------------------------------------
module scaler_v_ctrl #(
    parameter int LINE_SIZE_MAX  = 1024,
    parameter int LINE_STEP_LOG2 = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_wr,
    input  logic [15:0] cfg_in_h,
    input  logic [15:0] cfg_out_h,
    input  logic [15:0] cfg_line_size,
    input  logic        de_i,
    input  logic        vs_i,
    output logic [15:0] v_scale_step,
    output logic [15:0] v_scale_line_size,
    output logic        cfg_busy,
    output logic        cfg_err,
    output logic        frame_upd
);

    // Dividend is in_h << LINE_STEP_LOG2, carried as a 28-bit quotient register.
    localparam int DIV_W = 28;
    localparam int CNT_W = 5;

    localparam logic [15:0] STEP_RESET = 16'(1 << LINE_STEP_LOG2);
    localparam logic [15:0] LINE_RESET = 16'(LINE_SIZE_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        CHECK,
        PEND
    } state_t;

    state_t state, state_next;

    // Latched configuration and divider datapath
    logic [15:0]      out_h_q;
    logic [15:0]      line_q;
    logic [DIV_W-1:0] quo;      // shifts dividend out of the top, quotient in at the bottom
    logic [15:0]      rem;
    logic [CNT_W-1:0] cnt;

    logic [DIV_W-1:0] dvd_init;
    logic [16:0]      partial;
    logic [16:0]      diff;
    logic             q_bit;
    logic [15:0]      rem_next;

    logic boundary;
    logic bad_cfg;
    logic load_cfg;
    logic apply;
    logic reject;

    assign boundary = de_i & vs_i;
    assign dvd_init = DIV_W'(cfg_in_h) << LINE_STEP_LOG2;

    // One restoring-division step. The remainder stays below the divisor, so
    // the partial remainder fits 17 bits and bit 16 of the difference is the
    // borrow: clear means partial >= divisor and the quotient bit is 1.
    assign partial  = {rem, quo[DIV_W-1]};
    assign diff     = partial - {1'b0, out_h_q};
    assign q_bit    = ~diff[16];
    assign rem_next = q_bit ? diff[15:0] : partial[15:0];

    // Quotient is final while in CHECK.
    assign bad_cfg = (out_h_q == 16'd0)
                  || (quo == '0)
                  || (quo[DIV_W-1:16] != '0)
                  || (line_q == 16'd0)
                  || (int'(line_q) > LINE_SIZE_MAX);

    assign cfg_busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        load_cfg   = 1'b0;
        apply      = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_wr) begin
                    load_cfg   = 1'b1;
                    state_next = DIV;
                end
            end
            DIV: begin
                if (cnt == CNT_W'(DIV_W - 1)) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (bad_cfg) begin
                    reject     = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = PEND;
                end
            end
            PEND: begin
                // A fresh write wins over a coincident boundary: the stale
                // result is dropped and the divider restarts.
                if (cfg_wr) begin
                    load_cfg   = 1'b1;
                    state_next = DIV;
                end else if (boundary) begin
                    apply      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the divider datapath is not reset; every value it holds is
    // reloaded by load_cfg before the FSM can consume it.
    always_ff @(posedge clk) begin
        if (load_cfg) begin
            out_h_q <= cfg_out_h;
            line_q  <= cfg_line_size;
            quo     <= dvd_init;
            rem     <= '0;
            cnt     <= '0;
        end else if (state == DIV) begin
            quo <= {quo[DIV_W-2:0], q_bit};
            rem <= rem_next;
            cnt <= cnt + 1'b1;
        end
    end

    // Active outputs move only together with frame_upd.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_scale_step      <= STEP_RESET;
            v_scale_line_size <= LINE_RESET;
            cfg_err           <= 1'b0;
            frame_upd         <= 1'b0;
        end else begin
            frame_upd <= apply;
            if (apply) begin
                v_scale_step      <= quo[15:0];
                v_scale_line_size <= line_q - 16'd1;
            end
            if (load_cfg) begin
                cfg_err <= 1'b0;
            end else if (reject) begin
                cfg_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scaler_v_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scaler_v_ctrl
//
// Self-checking bench for scaler_v_ctrl (LINE_SIZE_MAX = 2048). Expected step
// and line size come from plain arithmetic on the configuration; the bench
// tracks the values currently in force and counts frame_upd pulses and any
// output change that is not accompanied by frame_upd.
// -----------------------------------------------------------------------------
module tb_scaler_v_ctrl;

    localparam int LMAX = 2048;
    localparam int SLOG = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [15:0] cfg_in_h;
    logic [15:0] cfg_out_h;
    logic [15:0] cfg_line_size;
    logic        de_i;
    logic        vs_i;
    logic [15:0] v_scale_step;
    logic [15:0] v_scale_line_size;
    logic        cfg_busy;
    logic        cfg_err;
    logic        frame_upd;

    scaler_v_ctrl #(
        .LINE_SIZE_MAX (LMAX),
        .LINE_STEP_LOG2(SLOG)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_wr           (cfg_wr),
        .cfg_in_h         (cfg_in_h),
        .cfg_out_h        (cfg_out_h),
        .cfg_line_size    (cfg_line_size),
        .de_i             (de_i),
        .vs_i             (vs_i),
        .v_scale_step     (v_scale_step),
        .v_scale_line_size(v_scale_line_size),
        .cfg_busy         (cfg_busy),
        .cfg_err          (cfg_err),
        .frame_upd        (frame_upd)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Values the scaler should currently be using.
    int exp_step;
    int exp_line;

    // Pulse counter and glitch monitor.
    int          upd_count    = 0;
    int          glitch_count = 0;
    logic [15:0] prev_step;
    logic [15:0] prev_line;
    logic        rst_d = 1'b1;

    always @(posedge clk) begin
        if (frame_upd === 1'b1) upd_count++;
        if (!rst_d && frame_upd !== 1'b1 &&
            (v_scale_step !== prev_step || v_scale_line_size !== prev_line))
            glitch_count++;
        prev_step = v_scale_step;
        prev_line = v_scale_line_size;
        rst_d     = rst;
    end

    // ---------------- reference model ----------------
    function automatic longint model_q(input int ih, input int oh);
        if (oh == 0) return -1;
        return (longint'(ih) * (longint'(1) << SLOG)) / longint'(oh);
    endfunction

    function automatic bit model_ok(input int ih, input int oh, input int ln);
        longint q;
        q = model_q(ih, oh);
        return (oh != 0) && (q > 0) && (q <= 65535) && (ln > 0) && (ln <= LMAX);
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write is presented during cycle 0; returns at cycle 1.
    task automatic write_cfg(input int ih, input int oh, input int ln);
        cfg_in_h      = 16'(ih);
        cfg_out_h     = 16'(oh);
        cfg_line_size = 16'(ln);
        cfg_wr        = 1'b1;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic frame();
        de_i = 1'b1;
        vs_i = 1'b1;
        tick();
        de_i = 1'b0;
        vs_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst      = 1'b0;
        exp_step = 1 << SLOG;
        exp_line = LMAX - 1;
    endtask

    // Full write -> compute -> boundary sequence with timing checks.
    task automatic apply_and_check(input int ih, input int oh, input int ln,
                                   input int gap, input string nm);
        bit ok;
        int u0;
        ok = model_ok(ih, oh, ln);
        u0 = upd_count;
        write_cfg(ih, oh, ln);
        n_tests++;
        if (cfg_busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy_c1 got %b want 1", nm, cfg_busy);
        end
        repeat (28) tick();
        n_tests++;
        if (cfg_busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy_c29 got %b want 1", nm, cfg_busy);
        end
        tick();
        n_tests++;
        if (cfg_err !== !ok || cfg_busy !== ok) begin
            n_fail++;
            $display("FAIL %s err/busy_c30 got %b/%b want %b/%b", nm, cfg_err, cfg_busy, !ok, ok);
        end
        repeat (gap) tick();
        n_tests++;
        if (v_scale_step !== 16'(exp_step) || v_scale_line_size !== 16'(exp_line)) begin
            n_fail++;
            $display("FAIL %s hold_pre got %0d/%0d want %0d/%0d", nm,
                     v_scale_step, v_scale_line_size, exp_step, exp_line);
        end
        frame();
        if (ok) begin
            exp_step = int'(model_q(ih, oh));
            exp_line = ln - 1;
        end
        n_tests++;
        if (frame_upd !== ok) begin
            n_fail++; $display("FAIL %s frame_upd got %b want %b", nm, frame_upd, ok);
        end
        n_tests++;
        if (v_scale_step !== 16'(exp_step) || v_scale_line_size !== 16'(exp_line)) begin
            n_fail++;
            $display("FAIL %s outputs got %0d/%0d want %0d/%0d", nm,
                     v_scale_step, v_scale_line_size, exp_step, exp_line);
        end
        tick();
        n_tests++;
        if (frame_upd !== 1'b0 || cfg_busy !== 1'b0 || (upd_count - u0) != int'(ok)) begin
            n_fail++;
            $display("FAIL %s after upd/busy/pulses got %b/%b/%0d want 0/0/%0d", nm,
                     frame_upd, cfg_busy, upd_count - u0, int'(ok));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int u0;
        rst = 1'b1;
        repeat (2) tick();
        n_tests++;
        if (v_scale_step !== 16'd4096 || v_scale_line_size !== 16'(LMAX - 1)) begin
            n_fail++;
            $display("FAIL reset_outputs got %0d/%0d want 4096/%0d",
                     v_scale_step, v_scale_line_size, LMAX - 1);
        end
        n_tests++;
        if (cfg_busy !== 1'b0 || cfg_err !== 1'b0 || frame_upd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b%b%b want 000", cfg_busy, cfg_err, frame_upd);
        end
        rst      = 1'b0;
        exp_step = 4096;
        exp_line = LMAX - 1;
        tick();
        u0 = upd_count;
        frame();
        tick();
        n_tests++;
        if (upd_count != u0 || cfg_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_boundary pulses/busy got %0d/%b want 0/0", upd_count - u0, cfg_busy);
        end
    endtask

    task automatic test_scale_down();
        apply_and_check(1080, 720, 1920, 3, "scale_down");
        n_tests++;
        if (v_scale_step !== 16'd6144 || v_scale_line_size !== 16'd1919) begin
            n_fail++;
            $display("FAIL scale_down_abs got %0d/%0d want 6144/1919", v_scale_step, v_scale_line_size);
        end
    endtask

    task automatic test_scale_up();
        apply_and_check(720, 1080, 1024, 0, "scale_up");
        n_tests++;
        if (v_scale_step !== 16'd2730 || v_scale_line_size !== 16'd1023) begin
            n_fail++;
            $display("FAIL scale_up_abs got %0d/%0d want 2730/1023", v_scale_step, v_scale_line_size);
        end
    endtask

    task automatic test_unity();
        apply_and_check(1080, 1080, 1024, 1, "unity");
    endtask

    task automatic test_out_h_zero();
        apply_and_check(720, 0, 1024, 2, "out_h_zero");
        n_tests++;
        if (v_scale_step !== 16'd4096 || v_scale_line_size !== 16'd1023 || cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL out_h_zero_abs got %0d/%0d err %b want 4096/1023 err 1",
                     v_scale_step, v_scale_line_size, cfg_err);
        end
    endtask

    task automatic test_overflow();
        apply_and_check(2000, 100, 1024, 1, "overflow");
    endtask

    task automatic test_line_limits();
        apply_and_check(1080, 1080, LMAX + 1, 0, "line_over_max");
        apply_and_check(1080, 1080, 0, 0, "line_zero");
        apply_and_check(0, 720, 100, 0, "q_zero");
        apply_and_check(1080, 1080, LMAX, 0, "line_at_max");
    endtask

    task automatic test_boundary_in_div();
        int u0;
        u0 = upd_count;
        write_cfg(720, 1080, 1024);
        repeat (4) tick();
        frame();
        n_tests++;
        if (frame_upd !== 1'b0 || cfg_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL div_boundary upd/busy got %b/%b want 0/1", frame_upd, cfg_busy);
        end
        repeat (24) tick();
        n_tests++;
        if (cfg_busy !== 1'b1 || upd_count != u0 || v_scale_step !== 16'(exp_step)) begin
            n_fail++;
            $display("FAIL div_boundary_pend busy/pulses/step got %b/%0d/%0d want 1/0/%0d",
                     cfg_busy, upd_count - u0, v_scale_step, exp_step);
        end
        frame();
        exp_step = 2730;
        exp_line = 1023;
        tick();
        n_tests++;
        if (v_scale_step !== 16'd2730 || upd_count - u0 != 1) begin
            n_fail++;
            $display("FAIL div_boundary_apply step/pulses got %0d/%0d want 2730/1",
                     v_scale_step, upd_count - u0);
        end
    endtask

    task automatic test_rewrite_in_pend();
        int u0;
        u0 = upd_count;
        write_cfg(1080, 720, 1920);
        repeat (29) tick();
        n_tests++;
        if (cfg_busy !== 1'b1 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rewrite_pend busy/err got %b/%b want 1/0", cfg_busy, cfg_err);
        end
        write_cfg(720, 1080, 1024);
        repeat (29) tick();
        frame();
        tick();
        exp_step = 2730;
        exp_line = 1023;
        n_tests++;
        if (v_scale_step !== 16'd2730 || v_scale_line_size !== 16'd1023 || upd_count - u0 != 1) begin
            n_fail++;
            $display("FAIL rewrite_apply got %0d/%0d pulses %0d want 2730/1023 pulses 1",
                     v_scale_step, v_scale_line_size, upd_count - u0);
        end
    endtask

    task automatic test_wr_with_boundary();
        int u0;
        u0 = upd_count;
        write_cfg(1080, 720, 1920);
        repeat (29) tick();
        de_i = 1'b1;
        vs_i = 1'b1;
        write_cfg(1080, 1080, 500);
        de_i = 1'b0;
        vs_i = 1'b0;
        n_tests++;
        if (frame_upd !== 1'b0 || cfg_busy !== 1'b1 || v_scale_step !== 16'(exp_step)) begin
            n_fail++;
            $display("FAIL wr_boundary upd/busy/step got %b/%b/%0d want 0/1/%0d",
                     frame_upd, cfg_busy, v_scale_step, exp_step);
        end
        repeat (29) tick();
        frame();
        tick();
        exp_step = 4096;
        exp_line = 499;
        n_tests++;
        if (v_scale_step !== 16'd4096 || v_scale_line_size !== 16'd499 || upd_count - u0 != 1) begin
            n_fail++;
            $display("FAIL wr_boundary_apply got %0d/%0d pulses %0d want 4096/499 pulses 1",
                     v_scale_step, v_scale_line_size, upd_count - u0);
        end
    endtask

    task automatic test_ignore_wr_in_div();
        write_cfg(720, 1080, 1024);
        repeat (3) tick();
        write_cfg(1080, 720, 1920);
        repeat (25) tick();
        n_tests++;
        if (cfg_busy !== 1'b1 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_wr busy/err got %b/%b want 1/0", cfg_busy, cfg_err);
        end
        frame();
        exp_step = 2730;
        exp_line = 1023;
        n_tests++;
        if (v_scale_step !== 16'd2730 || v_scale_line_size !== 16'd1023 || frame_upd !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_wr_apply got %0d/%0d upd %b want 2730/1023 upd 1",
                     v_scale_step, v_scale_line_size, frame_upd);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        int u0;
        write_cfg(1080, 720, 1920);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_step = 4096;
        exp_line = LMAX - 1;
        u0 = upd_count;
        frame();
        tick();
        n_tests++;
        if (v_scale_step !== 16'd4096 || v_scale_line_size !== 16'(LMAX - 1) ||
            cfg_busy !== 1'b0 || upd_count != u0) begin
            n_fail++;
            $display("FAIL reset_mid_div got %0d/%0d busy %b pulses %0d want 4096/%0d busy 0 pulses 0",
                     v_scale_step, v_scale_line_size, cfg_busy, upd_count - u0, LMAX - 1);
        end
        // Reset while an apply is pending.
        write_cfg(720, 1080, 1024);
        repeat (29) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        u0 = upd_count;
        frame();
        tick();
        n_tests++;
        if (v_scale_step !== 16'd4096 || cfg_busy !== 1'b0 || upd_count != u0) begin
            n_fail++;
            $display("FAIL reset_mid_pend got step %0d busy %b pulses %0d want 4096/0/0",
                     v_scale_step, cfg_busy, upd_count - u0);
        end
    endtask

    task automatic test_random();
        int ih, oh, ln, gap;
        for (int i = 0; i < 20; i++) begin
            ih  = int'($urandom_range(0, 4000));
            oh  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4000));
            ln  = int'($urandom_range(0, LMAX + 50));
            gap = int'($urandom_range(0, 4));
            apply_and_check(ih, oh, ln, gap, $sformatf("rand%0d_%0d_%0d_%0d", i, ih, oh, ln));
        end
    endtask

    initial begin
        rst           = 1'b1;
        cfg_wr        = 1'b0;
        cfg_in_h      = '0;
        cfg_out_h     = '0;
        cfg_line_size = '0;
        de_i          = 1'b0;
        vs_i          = 1'b0;
        exp_step      = 4096;
        exp_line      = LMAX - 1;

        test_reset();
        test_scale_down();
        test_scale_up();
        test_unity();
        test_out_h_zero();
        test_overflow();
        test_line_limits();
        test_boundary_in_div();
        test_rewrite_in_pend();
        test_wr_with_boundary();
        test_ignore_wr_in_div();
        test_reset_mid_div();
        do_reset();
        test_random();

        n_tests++;
        if (glitch_count != 0) begin
            n_fail++;
            $display("FAIL output_stability got %0d changes without frame_upd want 0", glitch_count);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
